// File: rtl/shift_issue_stage.sv
// Registered RV32I shift issue stage: decodes SLL/SRL/SRA(I) into shifter operands through a 2-entry skid buffer.
// Latency 1 cycle when empty; in_ready comes from registered state only; outputs hold while out_valid && !out_ready.
module shift_issue_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int RD_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [11:0]        in_imm,
    input  logic               in_use_imm,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [RD_W-1:0]    in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_a,
    output logic [1:0]         out_alufn,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [RD_W-1:0]    out_rd,
    output logic               out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [1:0]         alufn;
        logic [SHAMT_W-1:0] shamt;
        logic [RD_W-1:0]    rd;
        logic               illegal;
    } entry_t;

    entry_t             dec_dat;
    entry_t             m_dat;
    entry_t             s_dat;
    logic               m_vld;
    logic               s_vld;
    logic [6:0]         eff_f7;
    logic [SHAMT_W-1:0] eff_shamt;
    logic               accept;
    logic               pop;

    // Only rs2[4:0] matters for the register form; the rest never affects decode.
    logic unused_rs2;
    assign unused_rs2 = ^in_rs2[XLEN-1:SHAMT_W];

    always_comb begin
        eff_f7          = in_use_imm ? in_imm[11:5] : in_funct7;
        eff_shamt       = in_use_imm ? in_imm[SHAMT_W-1:0] : in_rs2[SHAMT_W-1:0];
        dec_dat.a       = in_rs1;
        dec_dat.rd      = in_rd;
        dec_dat.alufn   = 2'b11;
        dec_dat.shamt   = '0;
        dec_dat.illegal = 1'b1;
        if (in_funct3 == 3'b001 && eff_f7 == 7'b0000000) begin
            dec_dat.alufn   = 2'b01;
            dec_dat.shamt   = eff_shamt;
            dec_dat.illegal = 1'b0;
        end else if (in_funct3 == 3'b101 && eff_f7 == 7'b0000000) begin
            dec_dat.alufn   = 2'b00;
            dec_dat.shamt   = eff_shamt;
            dec_dat.illegal = 1'b0;
        end else if (in_funct3 == 3'b101 && eff_f7 == 7'b0100000) begin
            dec_dat.alufn   = 2'b10;
            dec_dat.shamt   = eff_shamt;
            dec_dat.illegal = 1'b0;
        end
    end

    assign in_ready = !s_vld;
    assign accept   = in_valid && in_ready && !flush;
    assign pop      = m_vld && out_ready;

    // Data registers are written only on load so held outputs never toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= '0;
            s_dat <= '0;
        end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (s_vld) begin
            if (pop) begin
                m_dat <= s_dat;
                s_vld <= 1'b0;
            end
        end else if (!m_vld || pop) begin
            m_vld <= accept;
            if (accept) begin
                m_dat <= dec_dat;
            end
        end else if (accept) begin
            s_vld <= 1'b1;
            s_dat <= dec_dat;
        end
    end

    assign out_valid   = m_vld;
    assign out_a       = m_dat.a;
    assign out_alufn   = m_dat.alufn;
    assign out_shamt   = m_dat.shamt;
    assign out_rd      = m_dat.rd;
    assign out_illegal = m_dat.illegal;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue stage directly upstream of the combinational shifter.
- Takes decoded RV32I shift instructions (SLL/SRL/SRA and SLLI/SRLI/SRAI) with their operands.
- Produces the shifter's `a`, `alufn[1:0]` and `shamt[4:0]` operands plus a destination tag.
- Uses a valid/ready handshake with a 2-entry skid buffer and a synchronous flush, so the shifter's input is always registered and upstream stalls never create combinational ready paths.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush; discards all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_rs1  in  XLEN  rs1 data; becomes the shift operand
- in_rs2  in  XLEN  rs2 data; bits [4:0] give shamt for the register form
- in_imm  in  12  I-type immediate; [4:0] is shamt, [11:5] is funct7 for the immediate form
- in_use_imm  in  1  1 = SLLI/SRLI/SRAI, 0 = SLL/SRL/SRA
- in_funct3  in  3  instruction funct3
- in_funct7  in  7  instruction funct7 (register form only)
- in_rd  in  RD_W  destination register
- out_valid  out  1  output entry valid
- out_ready  in  1  shifter/writeback side accepts the entry
- out_a  out  XLEN  operand to shift
- out_alufn  out  2  00 = SRL, 01 = SLL, 10 = SRA, 11 = pass-through (no shift)
- out_shamt  out  SHAMT_W  shift amount
- out_rd  out  RD_W  destination tag
- out_illegal  out  1  entry decoded as an illegal shift

Behaviour:
- Decode is combinational on the input side and is captured into the registers.
- Effective f7 = in_use_imm ? in_imm[11:5] : in_funct7.
- Effective shamt = in_use_imm ? in_imm[4:0] : in_rs2[4:0]. The upper rs2 bits are ignored and never flag illegal.
- funct3 = 001 and f7 = 0000000 -> alufn 01 (SLL).
- funct3 = 101 and f7 = 0000000 -> alufn 00 (SRL).
- funct3 = 101 and f7 = 0100000 -> alufn 10 (SRA).
- Any other combination -> alufn 11, illegal = 1, shamt forced to 0. Operand a and rd are still passed through.
- Storage is a main register M (drives all out_*) plus a skid register S.
- in_ready = !S.valid, derived from registered state only; there is no combinational in_valid/out_ready -> in_ready path.
- Accept occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready.
- M empty, or M popping with S empty: an accepted entry loads into M.
- M full and not popping: an accepted entry loads into S.
- M popping with S full: S moves into M and S empties. in_ready was 0 that cycle, so there is no accept.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry per cycle while out_ready stays high.
- out_valid = M.valid. out_* hold stable while out_valid && !out_ready.
- Ordering is strictly FIFO; entries are never reordered or duplicated.
- flush: next cycle M.valid = S.valid = 0. Any entry offered in the flush cycle is dropped, and a pop in the same cycle is still counted by the consumer.
- rst has priority over flush. rst clears M.valid and S.valid, and all data outputs go to 0: out_a = 0, out_alufn = 00, out_shamt = 0, out_rd = 0, out_illegal = 0. in_ready = 1 after reset.
- Reset or flush mid-stall discards held entries. No partial state survives.
- Data registers are only written on load, to avoid toggling out_* while holding.

Test Plan:
1. Reset, then SLL (rs1 = 0x0000_00F0, rs2 = 0x0000_0024, funct3 = 001, funct7 = 0) -> out_valid one cycle later, out_a = 0x0000_00F0, alufn = 01, shamt = 4, out_illegal = 0.
2. SRAI (imm = 0x41F, funct3 = 101, rs1 = 0x8000_0000) -> alufn = 10, shamt = 31. SRLI with imm = 0x003 -> alufn = 00, shamt = 3.
3. Illegal cases: funct3 = 001 with funct7 = 0100000, and funct3 = 000 -> alufn = 11, shamt = 0, out_illegal = 1, rd passed through.
4. Back-pressure: out_ready = 0 while 3 entries are offered back-to-back.
   - Entry 1 goes to M, entry 2 goes to S, then in_ready drops to 0.
   - Entry 3 waits.
   - Raising out_ready delivers entries 1, 2, 3 in order with no loss.
5. Streaming 16 entries with out_ready = 1 -> one output per cycle, in_ready never drops, and output order matches input order.
6. With M and S full, assert flush together with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the flushed and offered entries never appear. Repeat with rst asserted mid-stall -> all outputs are 0.
